// File: rtl/uart_tx_buffered_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// The FSM encoding and the parity rule live here so the top and any future RX side agree.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Mode 2'b11 is not a legal encoding and falls back to no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [1:0] mode, input logic xr);
    return (mode == PAR_ODD) ? ~xr : xr;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Show-ahead synchronous FIFO: rdata is valid whenever empty is low.
// Simultaneous push and pop are both honoured and leave the level unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == LW'(DEPTH));
  assign empty  = (r_count == '0);
  assign level  = r_count;
  assign rdata  = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is not reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a small FIFO; frames go out back-to-back while words are queued.
// Parity mode and stop-bit count are captured per frame when the word is popped.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int BITS_N       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [BITS_N-1:0]               data_tx,
  input  logic                            valid,
  output logic                            tx_ready,
  input  logic [1:0]                      parity_mode,
  input  logic                            stop2,
  output logic                            uart_tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_N);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_N - 1);

  tx_state_e         r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [BITS_N-1:0] r_shift;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_stop2;
  logic              r_tx;

  logic [BITS_N-1:0] w_fifo_data;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic              w_push;
  logic              w_pop;
  logic              w_last_cnt;
  logic              w_final_stop;

  assign tx_ready     = !w_full;
  assign w_push       = valid && !w_full && !reset;
  assign w_last_cnt   = (r_cnt == LAST_CNT);
  // r_bit doubles as the stop-bit index: 0 = first stop, 1 = second stop.
  assign w_final_stop = (r_state == ST_STOP) && w_last_cnt && (!r_stop2 || r_bit[0]);
  assign w_pop        = !w_empty && !reset && ((r_state == ST_IDLE) || w_final_stop);

  assign uart_tx    = r_tx;
  assign fifo_level = w_level;
  assign busy       = (r_state != ST_IDLE) || (w_level != '0);

  sync_fifo #(
    .WIDTH (BITS_N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (data_tx),
    .pop   (w_pop),
    .rdata (w_fifo_data),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      if (w_pop) begin
        r_shift   <= w_fifo_data;
        r_par_en  <= parity_enabled(parity_mode);
        r_par_bit <= parity_bit(parity_mode, ^w_fifo_data);
        r_stop2   <= stop2;
      end
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (w_pop) begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end else begin
            r_tx <= 1'b1;
          end
        end
        ST_START: begin
          if (w_last_cnt) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_last_cnt) begin
            r_cnt <= '0;
            if (r_bit == LAST_BIT) begin
              r_bit <= '0;
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              // LSB first: the next bit is always shift[1] before the shift lands.
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_last_cnt) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_last_cnt) begin
            r_cnt <= '0;
            if (w_final_stop) begin
              r_bit <= '0;
              if (w_pop) begin
                r_state <= ST_START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at 4 clocks per bit: a scoreboard of queued words
// is consumed by a line monitor that decodes every frame on uart_tx.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
  localparam int BN  = 8;
  localparam int FD  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_tx;
  logic       valid;
  logic       tx_ready;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .BITS_N       (BN),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_tx     (data_tx),
    .valid       (valid),
    .tx_ready    (tx_ready),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       s2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Line-level frame image, bit 0 = start bit.
  function automatic void mk_frame(input exp_t e, output logic [15:0] v, output int n);
    v    = '1;
    v[0] = 1'b0;
    for (int i = 0; i < 8; i++) v[1+i] = e.d[i];
    n = 9;
    if (e.pm == 2'b01 || e.pm == 2'b10) begin
      v[n] = (e.pm == 2'b01) ? ^e.d : ~^e.d;
      n++;
    end
    v[n] = 1'b1;
    n++;
    if (e.s2) begin
      v[n] = 1'b1;
      n++;
    end
  endfunction

  // Monitor: a low line outside reset starts a frame; every cycle of every bit must match.
  initial begin : monitor
    exp_t        e;
    logic [15:0] ev;
    logic [15:0] av;
    int          n;
    logic        gl;
    logic        ab;
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          mk_frame(e, ev, n);
          av = '1;
          gl = 1'b0;
          ab = 1'b0;
          for (int c = 0; c < n*CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (reset) begin
              ab = 1'b1;
              break;
            end
            if (c % CPB == 0) av[c/CPB] = uart_tx;
            else if (uart_tx !== av[c/CPB]) gl = 1'b1;
          end
          if (!ab) chk($sformatf("frame_%02h", e.d), {15'b0, gl, av}, {16'b0, ev});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input bit keep, output int waits);
    exp_t e;
    data_tx = d;
    valid   = 1'b1;
    waits   = 0;
    while (!tx_ready && waits < 2000) begin
      @(posedge clk);
      @(negedge clk);
      waits++;
    end
    chk("accept_rdy", 32'(tx_ready), 1);
    if (tx_ready) begin
      e.d  = d;
      e.pm = parity_mode;
      e.s2 = stop2;
      @(posedge clk);
      sb.push_back(e);
      @(negedge clk);
    end
    if (!keep) valid = 1'b0;
  endtask

  // Cycles from acceptance until busy falls = 1 + frame length.
  task automatic send_and_time(input logic [7:0] d, input bit tgl, output int cyc);
    int w;
    send(d, 1'b0, w);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      if (tgl && cyc == 10) stop2 = ~stop2;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  initial begin : stim
    int         w;
    int         cyc;
    logic [9:0] vec;

    reset       = 1'b1;
    valid       = 1'b1;
    data_tx     = 8'hEE;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    reset = 1'b0;
    valid = 1'b0;
    @(negedge clk);

    // 0xA5, no parity, one stop
    send(8'hA5, 1'b0, w);
    chk("a5_level", 32'(fifo_level), 1);
    chk("a5_pre_start", 32'(uart_tx), 1);
    @(negedge clk);
    chk("a5_latency", 32'(uart_tx), 0);
    vec = '0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (c % CPB == 2) vec[c/CPB] = uart_tx;
      if (c == 39) chk("a5_busy_last", 32'(busy), 1);
    end
    vec[0] = 1'b0;
    @(negedge clk);
    chk("a5_busy_drop", 32'(busy), 0);
    chk("a5_bits", 32'(vec), 32'(10'b1101001010));
    @(negedge clk);

    // even / odd parity on 0x07
    parity_mode = 2'b01;
    send_and_time(8'h07, 1'b0, cyc);
    chk("par_even_len", cyc, 45);
    parity_mode = 2'b10;
    send_and_time(8'h07, 1'b0, cyc);
    chk("par_odd_len", cyc, 45);
    parity_mode = 2'b11;
    send_and_time(8'h3C, 1'b0, cyc);
    chk("par_11_len", cyc, 41);
    parity_mode = 2'b00;

    // burst of six words into a 4-deep FIFO
    send(8'h11, 1'b1, w);
    send(8'h12, 1'b1, w);
    send(8'h13, 1'b1, w);
    send(8'h14, 1'b1, w);
    send(8'h15, 1'b1, w);
    chk("burst_level_full", 32'(fifo_level), 4);
    chk("burst_not_ready", 32'(tx_ready), 0);
    send(8'h16, 1'b0, w);
    chk("burst_w6_wait", w, 37);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk("burst_contiguous", cyc, 199);

    // two stop bits, toggled mid-frame
    stop2 = 1'b1;
    send_and_time(8'hFF, 1'b1, cyc);
    chk("stop2_len", cyc, 45);
    chk("stop2_toggled", 32'(stop2), 0);
    send_and_time(8'h81, 1'b0, cyc);
    chk("stop1_after_len", cyc, 41);

    // reset during data bit 3 with words still queued
    send(8'h3C, 1'b1, w);
    send(8'h55, 1'b1, w);
    send(8'h66, 1'b0, w);
    repeat (15) @(negedge clk);
    chk("pre_rst_level", 32'(fifo_level), 2);
    reset   = 1'b1;
    valid   = 1'b1;
    data_tx = 8'h99;
    @(negedge clk);
    chk("midrst_uart_tx", 32'(uart_tx), 1);
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_ready", 32'(tx_ready), 1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    send_and_time(8'h5A, 1'b0, cyc);
    chk("post_rst_len", cyc, 41);

    // push and pop on the same edge at level 2
    send(8'h21, 1'b1, w);
    send(8'h22, 1'b1, w);
    send(8'h23, 1'b0, w);
    repeat (38) @(negedge clk);
    chk("pp_level_before", 32'(fifo_level), 2);
    chk("pp_ready", 32'(tx_ready), 1);
    send(8'h24, 1'b0, w);
    chk("pp_level_after", 32'(fifo_level), 2);
    wait_idle();

    // stress: random data and gaps, fixed framing
    parity_mode = 2'b01;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 1'b0, w);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
